up_count_timer: RTL



---
 rtl/counter_pkg.sv | 14 +
 rtl/up_count_core.sv | 29 ++
 rtl/up_count_timer.sv | 103 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter/timer blocks: FSM state encoding and
// the one-shot/periodic mode encoding.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : counter_pkg

// File: rtl/up_count_core.sv
// Counting datapath for up_count_timer: the count register with synchronous
// clear and increment, plus the terminal compare.
module up_count_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);

  // The controller never asserts step at the terminal value, so the count
  // cannot run past term and the increment never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= count + 1'b1;
    end
  end

  assign at_term = (count == term);

endmodule : up_count_core

// File: rtl/up_count_timer.sv
// Loadable up-counting interval timer: counts from zero to a loaded terminal
// value, pulses tc_pulse for one cycle, then stops (one-shot) or wraps (periodic).
module up_count_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] terminal_value,
  output logic [WIDTH-1:0] out,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done
);

  import counter_pkg::*;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] term_reg;
  logic             mode_reg;
  logic             at_term;
  logic             terminal_cycle;
  logic             count_clear;
  logic             count_step;
  logic             tc_next;
  logic             busy_next;
  logic             done_next;

  // A load always overrides counting, including on the terminal cycle.
  assign terminal_cycle = (state == ST_RUN) && enable && at_term && !load;
  assign count_step     = (state == ST_RUN) && enable && !at_term && !load;
  assign count_clear    = load || (terminal_cycle && (mode_reg == MODE_PERIODIC));

  up_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (count_clear),
    .step    (count_step),
    .term    (term_reg),
    .count   (out),
    .at_term (at_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_reg <= '0;
      mode_reg <= MODE_ONESHOT;
    end else if (load) begin
      term_reg <= terminal_value;
      mode_reg <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (load) begin
      next_state = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (terminal_cycle && (mode_reg == MODE_ONESHOT)) begin
            next_state = ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: next_state = state;
        default:          next_state = ST_IDLE;
      endcase
    end
  end

  // Status flags are registered from next_state so they move with the state.
  always_comb begin
    tc_next   = terminal_cycle;
    busy_next = (next_state == ST_RUN);
    done_next = (next_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_pulse <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tc_pulse <= tc_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

endmodule : up_count_timer
